scr1_tcm_dmem_arb: RTL and testbench

- Two-master arbiter that shares the TCM data port between the core data interface (master 0) and a system DMA/debug master (master 1).
- Both masters use the standard SCR1 dmem protocol: req/req_ack, cmd, width, addr, wdata, rdata, and resp of type NOTRDY/RDY_OK/RDY_ER.
- Sits between the core/DMA and the TCM data port.
- Tracks one outstanding transaction, routes each response back to the master that issued it, and rejects out-of-range addresses locally with an error response.

---
 rtl/scr1_tcm_dmem_arb.sv | 148 ++++++++++++++
 tb/tb_scr1_tcm_dmem_arb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_tcm_dmem_arb.sv
// Two-master arbiter for the TCM data port: the core (m0) and the DMA/debug master (m1)
// share one port, with one transaction in flight and local error replies for out-of-range addresses.

package scr1_memif_pkg;
    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

module scr1_tcm_dmem_arb
    import scr1_memif_pkg::*;
#(
    parameter logic [31:0] SCR1_TCM_SIZE = 32'h00010000,
    parameter bit          ARB_RR        = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m0_req,
    input  type_scr1_mem_cmd_e   m0_cmd,
    input  type_scr1_mem_width_e m0_width,
    input  logic [31:0]          m0_addr,
    input  logic [31:0]          m0_wdata,
    output logic                 m0_req_ack,
    output logic [31:0]          m0_rdata,
    output type_scr1_mem_resp_e  m0_resp,
    input  logic                 m1_req,
    input  type_scr1_mem_cmd_e   m1_cmd,
    input  type_scr1_mem_width_e m1_width,
    input  logic [31:0]          m1_addr,
    input  logic [31:0]          m1_wdata,
    output logic                 m1_req_ack,
    output logic [31:0]          m1_rdata,
    output type_scr1_mem_resp_e  m1_resp,
    output logic                 s_req,
    output type_scr1_mem_cmd_e   s_cmd,
    output type_scr1_mem_width_e s_width,
    output logic [31:0]          s_addr,
    output logic [31:0]          s_wdata,
    input  logic                 s_req_ack,
    input  logic [31:0]          s_rdata,
    input  type_scr1_mem_resp_e  s_resp
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT_S = 2'b01,
        WAIT_E = 2'b10
    } state_e;

    state_e      state;
    logic        owner;
    logic        rr_last;

    logic        done_s;
    logic        can_accept;
    logic        winner;
    logic        any_req;
    logic        in_range;
    logic        grant;
    logic [31:0] win_addr;

    // Arbitration and forwarding; gated by rst_n so that every output drops to idle during reset.
    always_comb begin
        done_s     = (state == WAIT_S) && (s_resp != SCR1_MEM_RESP_NOTRDY);
        can_accept = rst_n && ((state == IDLE) || done_s || (state == WAIT_E));

        if (m0_req && m1_req) begin
            winner = ARB_RR ? !rr_last : 1'b0;
        end else begin
            winner = !m0_req;
        end

        any_req  = can_accept && (m0_req || m1_req);
        win_addr = winner ? m1_addr : m0_addr;
        in_range = win_addr < SCR1_TCM_SIZE;

        s_req   = any_req && in_range;
        s_cmd   = winner ? m1_cmd   : m0_cmd;
        s_width = winner ? m1_width : m0_width;
        s_addr  = win_addr;
        s_wdata = winner ? m1_wdata : m0_wdata;

        grant      = any_req && (!in_range || s_req_ack);
        m0_req_ack = grant && !winner;
        m1_req_ack = grant && winner;
    end

    // Response routing back to whichever master owns the outstanding transaction.
    always_comb begin
        m0_resp  = SCR1_MEM_RESP_NOTRDY;
        m1_resp  = SCR1_MEM_RESP_NOTRDY;
        m0_rdata = 32'h0;
        m1_rdata = 32'h0;
        if (rst_n) begin
            case (state)
                WAIT_S: begin
                    if (owner) begin
                        m1_resp  = s_resp;
                        m1_rdata = s_rdata;
                    end else begin
                        m0_resp  = s_resp;
                        m0_rdata = s_rdata;
                    end
                end
                WAIT_E: begin
                    if (owner) begin
                        m1_resp = SCR1_MEM_RESP_RDY_ER;
                    end else begin
                        m0_resp = SCR1_MEM_RESP_RDY_ER;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= 1'b0;
            rr_last <= 1'b1;
        end else if (grant) begin
            owner   <= winner;
            rr_last <= winner;
            state   <= in_range ? WAIT_S : WAIT_E;
        end else if (done_s || (state == WAIT_E)) begin
            state <= IDLE;
        end
    end

    // A TCM response with nothing outstanding is a protocol error by the TCM.
    assert property (@(posedge clk) disable iff (!rst_n)
        !((state == IDLE) && (s_resp != SCR1_MEM_RESP_NOTRDY)));

endmodule

// File: tb/tb_scr1_tcm_dmem_arb.sv
// Directed bench for scr1_tcm_dmem_arb: a round-robin instance driven by a tiny TCM model,
// plus a fixed-priority instance sharing the same master inputs.

module tb_scr1_tcm_dmem_arb;
    import scr1_memif_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic                 m0_req, m1_req;
    type_scr1_mem_cmd_e   m0_cmd, m1_cmd;
    type_scr1_mem_width_e m0_width, m1_width;
    logic [31:0]          m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic                 m0_req_ack, m1_req_ack;
    logic [31:0]          m0_rdata, m1_rdata;
    type_scr1_mem_resp_e  m0_resp, m1_resp;
    logic                 s_req, s_req_ack;
    type_scr1_mem_cmd_e   s_cmd;
    type_scr1_mem_width_e s_width;
    logic [31:0]          s_addr, s_wdata, s_rdata;
    type_scr1_mem_resp_e  s_resp;

    logic                 fx_m0_req_ack, fx_m1_req_ack, fx_s_req;
    logic [31:0]          fx_m0_rdata, fx_m1_rdata, fx_s_addr, fx_s_wdata;
    type_scr1_mem_resp_e  fx_m0_resp, fx_m1_resp, fx_s_resp;
    type_scr1_mem_cmd_e   fx_s_cmd;
    type_scr1_mem_width_e fx_s_width;

    logic [31:0] mem [0:63];
    int checks;
    int errors;

    scr1_tcm_dmem_arb #(.SCR1_TCM_SIZE(32'h00010000), .ARB_RR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_width(m0_width), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_req_ack(m0_req_ack), .m0_rdata(m0_rdata), .m0_resp(m0_resp),
        .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_width(m1_width), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_req_ack(m1_req_ack), .m1_rdata(m1_rdata), .m1_resp(m1_resp),
        .s_req(s_req), .s_cmd(s_cmd), .s_width(s_width), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_req_ack(s_req_ack), .s_rdata(s_rdata), .s_resp(s_resp)
    );

    scr1_tcm_dmem_arb #(.SCR1_TCM_SIZE(32'h00010000), .ARB_RR(1'b0)) dut_fixed (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_width(m0_width), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_req_ack(fx_m0_req_ack), .m0_rdata(fx_m0_rdata), .m0_resp(fx_m0_resp),
        .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_width(m1_width), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_req_ack(fx_m1_req_ack), .m1_rdata(fx_m1_rdata), .m1_resp(fx_m1_resp),
        .s_req(fx_s_req), .s_cmd(fx_s_cmd), .s_width(fx_s_width), .s_addr(fx_s_addr),
        .s_wdata(fx_s_wdata), .s_req_ack(s_req_ack), .s_rdata(32'h0), .s_resp(fx_s_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive both masters and the TCM accept line, then settle to the negedge for sampling.
    task automatic applyStimulus(
        input logic r0, input type_scr1_mem_cmd_e c0, input logic [31:0] a0, input logic [31:0] d0,
        input logic r1, input type_scr1_mem_cmd_e c1, input logic [31:0] a1, input logic [31:0] d1,
        input logic ack);
        m0_req = r0; m0_cmd = c0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_cmd = c1; m1_addr = a1; m1_wdata = d1;
        s_req_ack = ack;
        @(negedge clk);
    endtask

    // TCM model with 1-cycle latency: whatever is accepted this cycle answers next cycle.
    task automatic advanceCycle();
        logic               acc, fx_acc;
        type_scr1_mem_cmd_e cmd;
        logic [31:0]        addr, wdata;
        acc    = s_req && s_req_ack;
        fx_acc = fx_s_req && s_req_ack;
        cmd    = s_cmd;
        addr   = s_addr;
        wdata  = s_wdata;
        @(posedge clk);
        #1;
        if (acc) begin
            s_resp = SCR1_MEM_RESP_RDY_OK;
            if (cmd == SCR1_MEM_CMD_WR) begin
                mem[addr[7:2]] = wdata;
                s_rdata = 32'h0;
            end else begin
                s_rdata = mem[addr[7:2]];
            end
        end else begin
            s_resp  = SCR1_MEM_RESP_NOTRDY;
            s_rdata = 32'h0;
        end
        fx_s_resp = fx_acc ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
    endtask

    localparam type_scr1_mem_cmd_e RD = SCR1_MEM_CMD_RD;
    localparam type_scr1_mem_cmd_e WR = SCR1_MEM_CMD_WR;
    localparam logic [31:0] NOTRDY = 32'(SCR1_MEM_RESP_NOTRDY);
    localparam logic [31:0] RDY_OK = 32'(SCR1_MEM_RESP_RDY_OK);
    localparam logic [31:0] RDY_ER = 32'(SCR1_MEM_RESP_RDY_ER);

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4]  = 32'hDEADBEEF;
        mem[9]  = 32'hCAFE0024;
        mem[10] = 32'h0BADF00D;
        m0_width  = SCR1_MEM_WIDTH_WORD;
        m1_width  = SCR1_MEM_WIDTH_BYTE;
        s_resp    = SCR1_MEM_RESP_NOTRDY;
        fx_s_resp = SCR1_MEM_RESP_NOTRDY;
        s_rdata   = 32'h0;
        rst_n     = 1'b0;

        // Reset state
        applyStimulus(0, RD, 0, 0, 0, RD, 0, 0, 0);
        checkOutput("rst_m0_ack",   32'(m0_req_ack), 0);
        checkOutput("rst_m1_ack",   32'(m1_req_ack), 0);
        checkOutput("rst_m0_resp",  32'(m0_resp), NOTRDY);
        checkOutput("rst_m1_resp",  32'(m1_resp), NOTRDY);
        checkOutput("rst_m0_rdata", m0_rdata, 0);
        checkOutput("rst_s_req",    32'(s_req), 0);
        advanceCycle();
        rst_n = 1'b1;

        // Single read from master 0
        applyStimulus(1, RD, 32'h10, 0, 0, RD, 0, 0, 1);
        checkOutput("rd_m0_ack",    32'(m0_req_ack), 1);
        checkOutput("rd_s_req",     32'(s_req), 1);
        checkOutput("rd_s_addr",    s_addr, 32'h10);
        checkOutput("rd_s_width",   32'(s_width), 32'(SCR1_MEM_WIDTH_WORD));
        checkOutput("rd_m1_resp0",  32'(m1_resp), NOTRDY);
        advanceCycle();
        applyStimulus(0, RD, 0, 0, 0, RD, 0, 0, 0);
        checkOutput("rd_m0_resp",   32'(m0_resp), RDY_OK);
        checkOutput("rd_m0_rdata",  m0_rdata, 32'hDEADBEEF);
        checkOutput("rd_m1_resp1",  32'(m1_resp), NOTRDY);
        advanceCycle();

        // Out-of-range request from master 1
        applyStimulus(0, RD, 0, 0, 1, RD, 32'h00010000, 0, 1);
        checkOutput("oor_m1_ack",   32'(m1_req_ack), 1);
        checkOutput("oor_s_req",    32'(s_req), 0);
        advanceCycle();
        applyStimulus(0, RD, 0, 0, 0, RD, 0, 0, 0);
        checkOutput("oor_m1_resp",  32'(m1_resp), RDY_ER);
        checkOutput("oor_m1_rdata", m1_rdata, 0);
        checkOutput("oor_m0_resp",  32'(m0_resp), NOTRDY);
        advanceCycle();
        applyStimulus(0, RD, 0, 0, 0, RD, 0, 0, 0);
        checkOutput("oor_m1_once",  32'(m1_resp), NOTRDY);
        advanceCycle();

        // TCM stall for three cycles, then accept
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, RD, 32'h10, 0, 0, RD, 0, 0, 0);
            checkOutput("stall_s_req",  32'(s_req), 1);
            checkOutput("stall_m0_ack", 32'(m0_req_ack), 0);
            advanceCycle();
        end
        applyStimulus(1, RD, 32'h10, 0, 0, RD, 0, 0, 1);
        checkOutput("stall_go_ack", 32'(m0_req_ack), 1);
        advanceCycle();
        applyStimulus(0, RD, 0, 0, 0, RD, 0, 0, 0);
        checkOutput("stall_resp",   32'(m0_resp), RDY_OK);
        checkOutput("stall_rdata",  m0_rdata, 32'hDEADBEEF);
        advanceCycle();

        // Reset while a response is on the bus
        applyStimulus(1, RD, 32'h10, 0, 0, RD, 0, 0, 1);
        advanceCycle();
        rst_n = 1'b0;
        applyStimulus(1, RD, 32'h24, 0, 1, WR, 32'h20, 32'h11223344, 1);
        checkOutput("mrst_m0_resp", 32'(m0_resp), NOTRDY);
        checkOutput("mrst_m1_resp", 32'(m1_resp), NOTRDY);
        checkOutput("mrst_s_req",   32'(s_req), 0);
        checkOutput("mrst_m0_ack",  32'(m0_req_ack), 0);
        advanceCycle();
        rst_n = 1'b1;

        // Round-robin back-to-back, with the fixed-priority instance watching the same inputs
        applyStimulus(1, RD, 32'h24, 0, 1, WR, 32'h20, 32'h11223344, 1);
        checkOutput("rr1_m0_ack",   32'(m0_req_ack), 1);
        checkOutput("rr1_m1_ack",   32'(m1_req_ack), 0);
        checkOutput("rr1_s_addr",   s_addr, 32'h24);
        checkOutput("fx1_m0_ack",   32'(fx_m0_req_ack), 1);
        checkOutput("fx1_m1_ack",   32'(fx_m1_req_ack), 0);
        advanceCycle();
        applyStimulus(1, RD, 32'h20, 0, 1, WR, 32'h20, 32'h11223344, 1);
        checkOutput("rr2_m1_ack",   32'(m1_req_ack), 1);
        checkOutput("rr2_m0_ack",   32'(m0_req_ack), 0);
        checkOutput("rr2_s_cmd",    32'(s_cmd), 32'(SCR1_MEM_CMD_WR));
        checkOutput("rr2_s_width",  32'(s_width), 32'(SCR1_MEM_WIDTH_BYTE));
        checkOutput("rr2_s_wdata",  s_wdata, 32'h11223344);
        checkOutput("rr2_m0_resp",  32'(m0_resp), RDY_OK);
        checkOutput("rr2_m0_rdata", m0_rdata, 32'hCAFE0024);
        checkOutput("rr2_m1_resp",  32'(m1_resp), NOTRDY);
        checkOutput("fx2_m0_ack",   32'(fx_m0_req_ack), 1);
        checkOutput("fx2_m1_ack",   32'(fx_m1_req_ack), 0);
        advanceCycle();
        applyStimulus(1, RD, 32'h20, 0, 1, RD, 32'h28, 0, 1);
        checkOutput("rr3_m0_ack",   32'(m0_req_ack), 1);
        checkOutput("rr3_m1_ack",   32'(m1_req_ack), 0);
        checkOutput("rr3_m1_resp",  32'(m1_resp), RDY_OK);
        checkOutput("rr3_m0_resp",  32'(m0_resp), NOTRDY);
        checkOutput("fx3_m0_ack",   32'(fx_m0_req_ack), 1);
        checkOutput("fx3_m1_ack",   32'(fx_m1_req_ack), 0);
        advanceCycle();
        applyStimulus(1, RD, 32'h24, 0, 1, RD, 32'h28, 0, 1);
        checkOutput("rr4_m1_ack",   32'(m1_req_ack), 1);
        checkOutput("rr4_m0_ack",   32'(m0_req_ack), 0);
        checkOutput("rr4_m0_resp",  32'(m0_resp), RDY_OK);
        checkOutput("rr4_m0_rdata", m0_rdata, 32'h11223344);
        advanceCycle();
        applyStimulus(0, RD, 0, 0, 0, RD, 0, 0, 0);
        checkOutput("rr5_m1_resp",  32'(m1_resp), RDY_OK);
        checkOutput("rr5_m1_rdata", m1_rdata, 32'h0BADF00D);
        checkOutput("rr5_m0_resp",  32'(m0_resp), NOTRDY);
        advanceCycle();
        applyStimulus(0, RD, 0, 0, 0, RD, 0, 0, 0);
        checkOutput("idle_m1_resp", 32'(m1_resp), NOTRDY);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
